// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared bus types for the data and instruction bus masters
package Types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  wstrobe_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_t;
endpackage

// File: rtl/bus_timeout_counter.sv
// rtl/bus_timeout_counter.sv - saturating bus watchdog; expired marks the last allowed wait cycle
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  logic [CW-1:0] count;

  // Stops at the terminal count so a stalled master never sees the watchdog wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && (count == LAST);
endmodule

// File: rtl/data_bus_master.sv
// rtl/data_bus_master.sv - runs one load/store access per valid/ready transaction on the data bus
module data_bus_master
  import Types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     core_valid,
  output logic     core_ready,
  input  logic     core_write,
  input  word_t    core_address,
  input  wstrobe_t core_wstrobe,
  input  word_t    core_wdata,
  output logic     core_done,
  output logic     core_error,
  output word_t    core_rdata,
  output logic     bus_valid,
  input  logic     bus_ready,
  output word_t    bus_address,
  output wstrobe_t bus_wstrobe,
  output word_t    bus_wdata,
  input  word_t    bus_rdata
);
  bus_state_t state;
  logic       is_write;
  logic       accept;
  logic       expired;

  assign core_ready = (state == IDLE) || (state == RESP);
  assign accept     = core_valid && core_ready;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (accept),
    .enable ((state == BUSY) && !bus_ready),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      is_write    <= 1'b0;
      bus_valid   <= 1'b0;
      core_done   <= 1'b0;
      core_error  <= 1'b0;
      core_rdata  <= '0;
      bus_address <= '0;
      bus_wstrobe <= '0;
      bus_wdata   <= '0;
    end else begin
      core_done  <= 1'b0;
      core_error <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (core_valid) begin
            state       <= BUSY;
            is_write    <= core_write;
            bus_valid   <= 1'b1;
            bus_address <= core_address & ~32'h3;
            bus_wstrobe <= core_write ? core_wstrobe : 4'b0000;
            bus_wdata   <= core_wdata;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          // A handshake on the terminal-count cycle wins over the watchdog.
          if (bus_ready) begin
            if (!is_write) core_rdata <= bus_rdata;
            state     <= RESP;
            bus_valid <= 1'b0;
            core_done <= 1'b1;
          end else if (expired) begin
            core_rdata <= '0;
            state      <= RESP;
            bus_valid  <= 1'b0;
            core_done  <= 1'b1;
            core_error <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_bus_master.sv
// tb/tb_data_bus_master.sv - randomized and directed checks of data_bus_master against a transaction model
module tb_data_bus_master;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_valid = 1'b0;
  logic        core_write = 1'b0;
  logic [31:0] core_address = '0;
  logic [3:0]  core_wstrobe = '0;
  logic [31:0] core_wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;

  logic        d4_ready, d4_done, d4_error, d4_valid;
  logic [31:0] d4_rdata, d4_address, d4_wdata;
  logic [3:0]  d4_wstrobe;
  logic        d0_ready, d0_done, d0_error, d0_valid;
  logic [31:0] d0_rdata, d0_address, d0_wdata;
  logic [3:0]  d0_wstrobe;

  logic        sel_ready, sel_done, sel_error, sel_valid;
  logic [31:0] sel_rdata, sel_address, sel_wdata;
  logic [3:0]  sel_wstrobe;

  bit          use4 = 1'b1;
  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_rdata = '0;

  always #5 clk = ~clk;

  data_bus_master #(.TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .core_valid(core_valid), .core_ready(d4_ready), .core_write(core_write),
    .core_address(core_address), .core_wstrobe(core_wstrobe), .core_wdata(core_wdata),
    .core_done(d4_done), .core_error(d4_error), .core_rdata(d4_rdata),
    .bus_valid(d4_valid), .bus_ready(bus_ready), .bus_address(d4_address),
    .bus_wstrobe(d4_wstrobe), .bus_wdata(d4_wdata), .bus_rdata(bus_rdata)
  );

  data_bus_master #(.TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .core_valid(core_valid), .core_ready(d0_ready), .core_write(core_write),
    .core_address(core_address), .core_wstrobe(core_wstrobe), .core_wdata(core_wdata),
    .core_done(d0_done), .core_error(d0_error), .core_rdata(d0_rdata),
    .bus_valid(d0_valid), .bus_ready(bus_ready), .bus_address(d0_address),
    .bus_wstrobe(d0_wstrobe), .bus_wdata(d0_wdata), .bus_rdata(bus_rdata)
  );

  always_comb begin
    sel_ready   = use4 ? d4_ready   : d0_ready;
    sel_done    = use4 ? d4_done    : d0_done;
    sel_error   = use4 ? d4_error   : d0_error;
    sel_valid   = use4 ? d4_valid   : d0_valid;
    sel_rdata   = use4 ? d4_rdata   : d0_rdata;
    sel_address = use4 ? d4_address : d0_address;
    sel_wdata   = use4 ? d4_wdata   : d0_wdata;
    sel_wstrobe = use4 ? d4_wstrobe : d0_wstrobe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Model: a transaction with `waits` not-ready cycles holds bus_valid for waits+1
  // cycles, unless an enabled watchdog of T cycles runs out first (T valid cycles).
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [3:0] ws,
                     input logic [31:0] wd, input int waits, input logic [31:0] rd);
    int          tmo;
    bit          to;
    int          v;
    int          n;
    int          nv;
    bit          seen;
    logic [31:0] ea;
    logic [3:0]  es;
    tmo  = use4 ? 4 : 0;
    to   = (tmo != 0) && (waits >= tmo);
    v    = to ? tmo : waits + 1;
    ea   = (addr / 4) * 4;
    es   = wr ? ws : 4'b0000;
    n    = 0;
    nv   = 0;
    seen = 1'b0;
    chk("ready_before_accept", {31'b0, sel_ready}, 32'd1);
    core_valid   = 1'b1;
    core_write   = wr;
    core_address = addr;
    core_wstrobe = ws;
    core_wdata   = wd;
    bus_ready    = 1'b0;
    bus_rdata    = ~rd;
    @(negedge clk);
    core_valid   = 1'b0;
    core_write   = $urandom_range(0, 1);
    core_address = $urandom;
    core_wstrobe = $urandom;
    core_wdata   = $urandom;
    while (!seen && n < 1200) begin
      n++;
      if (sel_done) begin
        seen = 1'b1;
      end else begin
        if (sel_valid) begin
          nv++;
          chk("bus_address", sel_address, ea);
          chk("bus_wstrobe", {28'b0, sel_wstrobe}, {28'b0, es});
          chk("bus_wdata", sel_wdata, wd);
          bus_ready = (nv == waits + 1);
          bus_rdata = bus_ready ? rd : ~rd;
        end
        @(negedge clk);
        bus_ready = 1'b0;
        bus_rdata = ~rd;
      end
    end
    if (to) exp_rdata = 32'h0;
    else if (!wr) exp_rdata = rd;
    chk("done_seen", {31'b0, seen}, 32'd1);
    chk("done_latency", n, v + 1);
    chk("valid_cycles", nv, v);
    chk("bus_valid_in_resp", {31'b0, sel_valid}, 32'd0);
    chk("core_error", {31'b0, sel_error}, {31'b0, to});
    chk("core_rdata", sel_rdata, exp_rdata);
    chk("ready_in_resp", {31'b0, sel_ready}, 32'd1);
  endtask

  task automatic idle_check();
    @(negedge clk);
    chk("done_one_cycle", {31'b0, sel_done}, 32'd0);
    chk("error_cleared", {31'b0, sel_error}, 32'd0);
  endtask

  initial begin
    #1;
    for (int k = 0; k < 2; k++) begin
      use4 = (k == 0);
      #0;
      chk("rst_ready", {31'b0, sel_ready}, 32'd1);
      chk("rst_valid", {31'b0, sel_valid}, 32'd0);
      chk("rst_done", {31'b0, sel_done}, 32'd0);
      chk("rst_error", {31'b0, sel_error}, 32'd0);
      chk("rst_rdata", sel_rdata, 32'd0);
      chk("rst_address", sel_address, 32'd0);
      chk("rst_wstrobe", {28'b0, sel_wstrobe}, 32'd0);
      chk("rst_wdata", sel_wdata, 32'd0);
    end
    use4 = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    txn(1'b0, 32'h0000_1006, 4'b1111, 32'h5555_AAAA, 0, 32'hDEAD_BEEF);
    idle_check();
    txn(1'b1, 32'h0000_0202, 4'b1100, 32'h1234_1234, 3, 32'h0BAD_F00D);
    idle_check();
    txn(1'b0, 32'h0000_0300, 4'b0000, 32'h0, 50, 32'h1111_2222);
    idle_check();
    txn(1'b0, 32'h0000_0040, 4'b0000, 32'h0, 0, 32'hCAFE_0001);
    txn(1'b0, 32'h0000_0045, 4'b1010, 32'h0, 2, 32'hCAFE_0002);
    idle_check();
    txn(1'b1, 32'h0000_0807, 4'b0000, 32'h7777_8888, 1, 32'h0);
    idle_check();
    txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0, 3, 32'hABCD_0003);
    txn(1'b1, 32'h0000_0014, 4'b0011, 32'h0, 4, 32'h0);
    idle_check();

    for (int i = 0; i < 24; i++) begin
      txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
          int'($urandom_range(0, 6)), $urandom);
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    @(negedge clk);
    core_valid   = 1'b1;
    core_write   = 1'b0;
    core_address = 32'h0000_0100;
    bus_ready    = 1'b0;
    @(negedge clk);
    core_valid = 1'b0;
    chk("midbusy_valid_before_reset", {31'b0, sel_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midbusy_valid_async_drop", {31'b0, sel_valid}, 32'd0);
    @(negedge clk);
    chk("midbusy_no_done", {31'b0, sel_done}, 32'd0);
    reset_n = 1'b1;
    exp_rdata = 32'h0;
    @(negedge clk);
    chk("midbusy_no_done_after", {31'b0, sel_done}, 32'd0);
    chk("midbusy_ready_after", {31'b0, sel_ready}, 32'd1);
    chk("midbusy_valid_after", {31'b0, sel_valid}, 32'd0);

    use4 = 1'b0;
    #0;
    chk("wd_ready_idle", {31'b0, sel_ready}, 32'd1);
    txn(1'b0, 32'h0000_2003, 4'b0000, 32'h0, 1000, 32'h600D_DA7A);
    idle_check();
    txn(1'b1, 32'h0000_2008, 4'b0110, 32'h9999_0000, 7, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
